// File: rtl/cache_dm_ctrl_if.sv
// cache_dm_ctrl_if: CPU request and memory bus bundle for the direct-mapped cache controller
interface cache_dm_ctrl_if;
    logic [15:0] Addr, DataIn, DataOut, m_addr, m_wdata, m_rdata;
    logic        Rd, Wr, Done, Stall, CacheHit, err, m_wr, m_rd, m_busy, m_err;
    modport master (
        output Addr, DataIn, Rd, Wr, m_rdata, m_busy, m_err,
        input  DataOut, Done, Stall, CacheHit, err, m_addr, m_wdata, m_wr, m_rd
    );
    modport slave (
        input  Addr, DataIn, Rd, Wr, m_rdata, m_busy, m_err,
        output DataOut, Done, Stall, CacheHit, err, m_addr, m_wdata, m_wr, m_rd
    );
endinterface

// File: rtl/cache_dm_ctrl.sv
// cache_dm_ctrl: direct-mapped write-back/write-allocate cache controller; CACHE_ERR_CHECK_EN adds request checks on err
module cache_dm_ctrl #(
    parameter int INDEX_W = 8,
    parameter int WOFF_W  = 2,
    parameter int MEM_LAT = 2
) (
    input logic           clk,
    input logic           rst,
    cache_dm_ctrl_if.slave bus
);
    localparam int TAG_W = 15 - INDEX_W - WOFF_W;
    localparam int LINES = 1 << INDEX_W;
    typedef enum logic [2:0] {IDLE, WB, FILL, DRAIN, FIN} state_t;
    state_t               state_q;
    logic [15:1]          addr_q;
    logic [15:0]          din_q, m_addr_q, m_wdata_q;
    logic                 wr_q, m_rd_q, m_wr_q, err_q;
    logic [WOFF_W-1:0]    beat_q, ret_q;
    logic [MEM_LAT-1:0]   pend_q, older;
    logic [LINES-1:0]     valid_q, dirty_q;
    logic [TAG_W-1:0]     tag_q [LINES];
    logic [15:0]          data_q [LINES << WOFF_W];
    logic [INDEX_W-1:0]   idx_i, idx_l;
    logic [TAG_W-1:0]     tag_i, tag_l;
    logic [WOFF_W-1:0]    word_i, word_l;
    logic                 req, hit, last, ret, acc, drained, err_chk;
    assign word_i  = bus.Addr[WOFF_W:1];
    assign idx_i   = bus.Addr[WOFF_W+INDEX_W:WOFF_W+1];
    assign tag_i   = bus.Addr[15:WOFF_W+INDEX_W+1];
    assign word_l  = addr_q[WOFF_W:1];
    assign idx_l   = addr_q[WOFF_W+INDEX_W:WOFF_W+1];
    assign tag_l   = addr_q[15:WOFF_W+INDEX_W+1];
    assign req     = !rst && (bus.Rd || bus.Wr);
    assign hit     = req && state_q == IDLE && valid_q[idx_i] && tag_q[idx_i] == tag_i;
    assign last    = &beat_q;
    assign ret     = pend_q[MEM_LAT-1];
    assign acc     = state_q == FILL && !bus.m_busy;
    // Only the oldest slot may still be occupied when the line is complete after this edge
    assign older   = pend_q << 1;
    assign drained = older == '0;
`ifdef CACHE_ERR_CHECK_EN
    assign err_chk = req && state_q == IDLE && ((bus.Rd && bus.Wr) || bus.Addr[0]);
`else
    assign err_chk = 1'b0;
`endif
    assign bus.Done     = hit || state_q == FIN;
    assign bus.CacheHit = hit;
    assign bus.Stall    = (state_q inside {WB, FILL, DRAIN}) || (req && state_q == IDLE && !hit);
    assign bus.DataOut  = hit && !bus.Wr ? data_q[{idx_i, word_i}] :
                          state_q == FIN && !wr_q ? data_q[{idx_l, word_l}] : '0;
    assign bus.m_addr   = m_addr_q;
    assign bus.m_wdata  = m_wdata_q;
    assign bus.m_rd     = m_rd_q;
    assign bus.m_wr     = m_wr_q;
    assign bus.err      = err_q;
    // Control FSM: beat sequencing, return tracking, line status bits and registered bus strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            din_q     <= '0;
            wr_q      <= 1'b0;
            beat_q    <= '0;
            ret_q     <= '0;
            pend_q    <= '0;
            valid_q   <= '0;
            dirty_q   <= '0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_rd_q    <= 1'b0;
            m_wr_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            pend_q <= (pend_q << 1) | MEM_LAT'(acc);
            err_q  <= bus.m_err || err_chk;
            if (ret) ret_q <= ret_q + 1'b1;
            case (state_q)
                IDLE: begin
                    if (hit) begin
                        if (bus.Wr) dirty_q[idx_i] <= 1'b1;
                    end else if (req) begin
                        addr_q <= bus.Addr[15:1];
                        din_q  <= bus.DataIn;
                        wr_q   <= bus.Wr;
                        beat_q <= '0;
                        ret_q  <= '0;
                        if (valid_q[idx_i] && dirty_q[idx_i]) begin
                            state_q   <= WB;
                            m_wr_q    <= 1'b1;
                            m_addr_q  <= {tag_q[idx_i], idx_i, {WOFF_W{1'b0}}, 1'b0};
                            m_wdata_q <= data_q[{idx_i, {WOFF_W{1'b0}}}];
                        end else begin
                            state_q  <= FILL;
                            m_rd_q   <= 1'b1;
                            m_addr_q <= {tag_i, idx_i, {WOFF_W{1'b0}}, 1'b0};
                        end
                    end
                end
                WB: begin
                    if (!bus.m_busy) begin
                        beat_q <= beat_q + 1'b1;
                        if (last) begin
                            state_q  <= FILL;
                            m_wr_q   <= 1'b0;
                            m_rd_q   <= 1'b1;
                            m_addr_q <= {tag_l, idx_l, {WOFF_W{1'b0}}, 1'b0};
                        end else begin
                            m_addr_q  <= {tag_q[idx_l], idx_l, beat_q + 1'b1, 1'b0};
                            m_wdata_q <= data_q[{idx_l, beat_q + 1'b1}];
                        end
                    end
                end
                FILL: begin
                    if (!bus.m_busy) begin
                        beat_q <= beat_q + 1'b1;
                        if (last) begin
                            state_q <= DRAIN;
                            m_rd_q  <= 1'b0;
                        end else begin
                            m_addr_q <= {tag_l, idx_l, beat_q + 1'b1, 1'b0};
                        end
                    end
                end
                DRAIN: begin
                    if (drained) begin
                        state_q        <= FIN;
                        valid_q[idx_l] <= 1'b1;
                        dirty_q[idx_l] <= 1'b0;
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                    if (wr_q) dirty_q[idx_l] <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    // Tag and data storage: hit writes, in-order fill returns, and the deferred miss write
    always_ff @(posedge clk) begin
        if (hit && bus.Wr) data_q[{idx_i, word_i}] <= bus.DataIn;
        else if (ret) data_q[{idx_l, ret_q}] <= bus.m_rdata;
        else if (state_q == FIN && wr_q) data_q[{idx_l, word_l}] <= din_q;
        if (state_q == DRAIN && drained) tag_q[idx_l] <= tag_l;
    end
endmodule

// File: doc/cache_dm_ctrl.md
CACHE_DM_CTRL -- requirements
Module: cache_dm_ctrl

Interface
REQ-001 Parameter INDEX_W, default 8, meaning log2 of the number of lines.
REQ-002 Parameter WOFF_W, default 2, meaning log2 of the 16-bit words per line (range 1..3).
REQ-003 Parameter MEM_LAT, default 2, meaning cycles from an accepted m_rd to valid m_rdata (range 1..4).
REQ-004 Derived TAG_W = 15 - INDEX_W - WOFF_W; address split: bit0 byte, [WOFF_W:1] word, next INDEX_W index, rest tag.
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 Addr  in  16  byte address of request.
REQ-008 DataIn  in  16  write data.
REQ-009 Rd  in  1  read request, sampled in IDLE only.
REQ-010 Wr  in  1  write request, sampled in IDLE only.
REQ-011 DataOut  out  16  read data, valid only while Done=1, else 0.
REQ-012 Done  out  1  one-cycle completion pulse.
REQ-013 Stall  out  1  busy, no new request accepted.
REQ-014 CacheHit  out  1  with Done, request hit without memory traffic.
REQ-015 err  out  1  error flag.
REQ-016 m_addr  out  16  word-aligned memory address.
REQ-017 m_wdata  out  16  memory write data.
REQ-018 m_wr  out  1  memory write strobe.
REQ-019 m_rd  out  1  memory read strobe.
REQ-020 m_rdata  in  16  memory read data, MEM_LAT cycles after accepted m_rd.
REQ-021 m_busy  in  1  memory refuses the strobe this cycle; strobe held, beat retried.
REQ-022 m_err  in  1  memory error, ORed into err.

Function
REQ-023 Internal direct-mapped arrays: 2^INDEX_W tags, valid and dirty bits, 2^(INDEX_W+WOFF_W) data words; write-back, write-allocate.
REQ-024 States SHALL be IDLE, WB, FILL, DRAIN, FIN.
REQ-025 IDLE with Rd or Wr and a valid tag match: Done=1, CacheHit=1, Stall=0 in the same cycle; DataOut=array word for reads; for writes, word and dirty bit updated at the clock edge.
REQ-026 IDLE miss: Addr, DataIn, Rd and Wr latched; Stall=1; next state WB if the victim is valid and dirty, else FILL.
REQ-027 WB: one m_wr beat per cycle not blocked by m_busy; m_addr = {victim tag, index, beat, 0}; after 2^WOFF_W beats go to FILL.
REQ-028 FILL: one m_rd beat per non-busy cycle, beats 0..2^WOFF_W-1; after the last beat issues, go to DRAIN.
REQ-029 Returns SHALL be tracked by a MEM_LAT-deep shift register of issued reads and written into the line in issue order; m_busy never drops an outstanding return.
REQ-030 DRAIN: wait until all returns are written, then set tag, valid=1, dirty=0 and go to FIN.
REQ-031 FIN: Done=1, CacheHit=0, Stall=0; read returns the requested word; write stores latched DataIn and sets dirty; next state IDLE.
REQ-032 Rd and Wr both high are treated as a write.
REQ-033 Rd/Wr changes outside IDLE are ignored; the latched request completes unchanged.

Reset
REQ-034 rst SHALL force IDLE, clear all valid and dirty bits, beat counters and the return shift register, and drive Done, Stall, CacheHit, m_rd, m_wr and err to 0 and DataOut, m_addr and m_wdata to 0.
REQ-035 rst during WB, FILL or DRAIN abandons the request with no Done; later returns are ignored.

Configuration
REQ-036 With CACHE_ERR_CHECK_EN defined: err=1 for one cycle in IDLE on Rd and Wr both high or Addr[0]=1; the request still executes per REQ-032 with bit0 ignored.
REQ-037 Without CACHE_ERR_CHECK_EN: err = registered m_err only; no request checks.

Verification (defaults)
REQ-038 After reset, Rd Addr 0x0010 -> FILL reads 0x0010,0x0012,0x0014,0x0016; Done with CacheHit=0 and DataOut=mem[0x0010].
REQ-039 Repeat Rd 0x0010 -> same-cycle Done, CacheHit=1, no m_rd.
REQ-040 Wr 0x0012 data 0xBEEF, then Rd 0x0812 (same index, new tag) -> WB of 4 words to 0x0010..0x0016 including 0xBEEF, then fill from 0x0810.
REQ-041 Hold m_busy=1 for 3 cycles during FILL beat 2 -> beat repeated until accepted; line contents correct; Done 3 cycles later than unstalled.
REQ-042 rst pulsed mid-FILL -> IDLE next cycle, no Done; following Rd 0x0010 misses.
REQ-043 CACHE_ERR_CHECK_EN defined, Rd 0x0011 -> err=1 one cycle; data for 0x0010 returned.
